// File: rtl/load_buffer_pkg.sv
// Shared widths, load opcodes, access-width encodings and stage type for the
// load buffer and its extension unit.
package load_buffer_pkg;

  localparam int INST_TYPE_W = 4;
  localparam int ROB_W       = 4;
  localparam int ID_W        = 32;
  localparam int ADDR_W      = 32;

  localparam logic [INST_TYPE_W-1:0] OP_LB  = 4'd1;
  localparam logic [INST_TYPE_W-1:0] OP_LH  = 4'd2;
  localparam logic [INST_TYPE_W-1:0] OP_LW  = 4'd3;
  localparam logic [INST_TYPE_W-1:0] OP_LBU = 4'd4;
  localparam logic [INST_TYPE_W-1:0] OP_LHU = 4'd5;

  localparam logic [2:0] W_BYTE = 3'b001;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_WORD = 3'b100;

  typedef enum logic {ST_IDLE, ST_MEM} lb_stage_e;

  // Memory access width for a load opcode; anything unknown reads a full word.
  function automatic logic [2:0] ld_width(input logic [INST_TYPE_W-1:0] op);
    case (op)
      OP_LB, OP_LBU: ld_width = W_BYTE;
      OP_LH, OP_LHU: ld_width = W_HALF;
      default:       ld_width = W_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_buffer_extend.sv
// load_extend: sign/zero extension of right-aligned load data by opcode.
// Shared by the forwarded-data and memory-data paths.
module load_extend
  import load_buffer_pkg::*;
(
  input  logic [INST_TYPE_W-1:0] opcode,
  input  logic [ID_W-1:0]        raw,
  output logic [ID_W-1:0]        result
);

  // Select the extension rule from the opcode; LW and unknown pass through.
  always_comb begin
    case (opcode)
      OP_LB:   result = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   result = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  result = {24'd0, raw[7:0]};
      OP_LHU:  result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// load_buffer: in-order queue of pending loads. The head load is offered to
// the ROB for disambiguation; once safe it reads memory (or takes forwarded
// store data) and broadcasts the extended result tagged with its ROB index.
// Optional macro LBUFFER_FORWARD_EN enables store-to-load forwarding.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LB_DEPTH = 8,
  parameter int LB_PTR_W = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_rst_in,
  output logic                   lbuffer_rdy_out,
  input  logic                   dispatcher_lbuffer_en_in,
  input  logic [INST_TYPE_W-1:0] dispatcher_lbuffer_opcode_in,
  input  logic [ROB_W-1:0]       dispatcher_lbuffer_h_in,
  input  logic [ROB_W-1:0]       addrunit_lbuffer_h_in,
  input  logic [ADDR_W-1:0]      addrunit_lbuffer_address_in,
  output logic [ROB_W-1:0]       lbuffer_rob_index_out,
  input  logic                   rob_lbuffer_disambiguation_in,
  input  logic                   rob_lbuffer_forwarding_en_in,
  input  logic [ID_W-1:0]        rob_lbuffer_forwarding_data_in,
  output logic                   lbuffer_datactrl_en_out,
  output logic [ADDR_W-1:0]      lbuffer_datactrl_addr_out,
  output logic [2:0]             lbuffer_datactrl_width_out,
  input  logic                   datactrl_lbuffer_en_in,
  input  logic [ID_W-1:0]        datactrl_lbuffer_data_in,
  output logic [ROB_W-1:0]       lbuffer_rob_h_out,
  output logic [ID_W-1:0]        lbuffer_rob_result_out
);

  logic [LB_DEPTH-1:0]                  busy, addr_valid;
  logic [LB_DEPTH-1:0][INST_TYPE_W-1:0] opc;
  logic [LB_DEPTH-1:0][ROB_W-1:0]       hh;
  logic [LB_DEPTH-1:0][ADDR_W-1:0]      addr;
  logic [LB_PTR_W-1:0]                  head, tail;
  logic [LB_PTR_W:0]                    count;
  lb_stage_e                            stage, stage_nx;

  logic            head_rdy, fwd_go, mem_done, deq, enq;
  logic [ID_W-1:0] ext_raw, ext_res;

  assign head_rdy = busy[head] & addr_valid[head];
  assign mem_done = (stage == ST_MEM) & datactrl_lbuffer_en_in;

`ifdef LBUFFER_FORWARD_EN
  assign fwd_go  = (stage == ST_IDLE) & head_rdy & rob_lbuffer_forwarding_en_in;
  assign ext_raw = mem_done ? datactrl_lbuffer_data_in : rob_lbuffer_forwarding_data_in;
`else
  // Forwarding inputs are deliberately ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{rob_lbuffer_forwarding_en_in, rob_lbuffer_forwarding_data_in};
  assign fwd_go     = 1'b0;
  assign ext_raw    = datactrl_lbuffer_data_in;
`endif

  // Flush blocks every queue update in its cycle, including a late response.
  assign deq = rdy_in & ~rob_rst_in & (fwd_go | mem_done);
  assign enq = rdy_in & ~rob_rst_in & dispatcher_lbuffer_en_in;

  assign lbuffer_rdy_out = (count <= (LB_PTR_W+1)'(LB_DEPTH - 2));

  load_extend u_ext (
    .opcode (opc[head]),
    .raw    (ext_raw),
    .result (ext_res)
  );

  // Stage register: flush and reset both return to IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in)          stage <= ST_IDLE;
    else if (rdy_in)     stage <= rob_rst_in ? ST_IDLE : stage_nx;
  end

  // Next stage: issue the head read once the ROB clears it.
  always_comb begin
    stage_nx = stage;
    case (stage)
      ST_IDLE: if (head_rdy && !fwd_go && rob_lbuffer_disambiguation_in) stage_nx = ST_MEM;
      ST_MEM:  if (datactrl_lbuffer_en_in) stage_nx = ST_IDLE;
      default: stage_nx = ST_IDLE;
    endcase
  end

  // Stage outputs: read request drops in the same cycle the data returns.
  always_comb begin
    lbuffer_datactrl_en_out    = (stage == ST_MEM) & ~datactrl_lbuffer_en_in;
    lbuffer_datactrl_addr_out  = addr[head];
    lbuffer_datactrl_width_out = ld_width(opc[head]);
    lbuffer_rob_index_out      = head_rdy ? hh[head] : '0;
  end

  // Queue storage, address capture, dequeue and the registered result port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head <= '0; tail <= '0; count <= '0;
      busy <= '0; addr_valid <= '0;
      lbuffer_rob_h_out <= '0; lbuffer_rob_result_out <= '0;
    end else if (rdy_in) begin
      lbuffer_rob_h_out <= '0;
      if (rob_rst_in) begin
        head <= '0; tail <= '0; count <= '0;
        busy <= '0; addr_valid <= '0;
        lbuffer_rob_result_out <= '0;
      end else begin
        if (enq) begin
          busy[tail]       <= 1'b1;
          opc[tail]        <= dispatcher_lbuffer_opcode_in;
          hh[tail]         <= dispatcher_lbuffer_h_in;
          addr_valid[tail] <= 1'b0;
          tail             <= tail + 1'b1;
        end
        // Capture after the enqueue write so a same-cycle address wins.
        for (int i = 0; i < LB_DEPTH; i++) begin
          if (addrunit_lbuffer_h_in != '0 &&
              ((busy[i] && hh[i] == addrunit_lbuffer_h_in) ||
               (enq && tail == LB_PTR_W'(i) && dispatcher_lbuffer_h_in == addrunit_lbuffer_h_in))) begin
            addr_valid[i] <= 1'b1;
            addr[i]       <= addrunit_lbuffer_address_in;
          end
        end
        if (deq) begin
          busy[head]             <= 1'b0;
          head                   <= head + 1'b1;
          lbuffer_rob_h_out      <= hh[head];
          lbuffer_rob_result_out <= ext_res;
        end
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: directed scenarios followed by randomized traffic,
// all checked against a queue-of-loads reference model.
module tb_load_buffer;
  import load_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic                   clk_in = 1'b0;
  logic                   rst_in, rdy_in, rob_rst_in, lbuffer_rdy_out;
  logic                   dispatcher_lbuffer_en_in;
  logic [INST_TYPE_W-1:0] dispatcher_lbuffer_opcode_in;
  logic [ROB_W-1:0]       dispatcher_lbuffer_h_in, addrunit_lbuffer_h_in, lbuffer_rob_index_out;
  logic [ADDR_W-1:0]      addrunit_lbuffer_address_in, lbuffer_datactrl_addr_out;
  logic                   rob_lbuffer_disambiguation_in, rob_lbuffer_forwarding_en_in;
  logic [ID_W-1:0]        rob_lbuffer_forwarding_data_in, datactrl_lbuffer_data_in;
  logic                   lbuffer_datactrl_en_out, datactrl_lbuffer_en_in;
  logic [2:0]             lbuffer_datactrl_width_out;
  logic [ROB_W-1:0]       lbuffer_rob_h_out;
  logic [ID_W-1:0]        lbuffer_rob_result_out;

  always #5 clk_in = ~clk_in;

  load_buffer #(.LB_DEPTH(DEPTH), .LB_PTR_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_rst_in(rob_rst_in),
    .lbuffer_rdy_out(lbuffer_rdy_out),
    .dispatcher_lbuffer_en_in(dispatcher_lbuffer_en_in),
    .dispatcher_lbuffer_opcode_in(dispatcher_lbuffer_opcode_in),
    .dispatcher_lbuffer_h_in(dispatcher_lbuffer_h_in),
    .addrunit_lbuffer_h_in(addrunit_lbuffer_h_in),
    .addrunit_lbuffer_address_in(addrunit_lbuffer_address_in),
    .lbuffer_rob_index_out(lbuffer_rob_index_out),
    .rob_lbuffer_disambiguation_in(rob_lbuffer_disambiguation_in),
    .rob_lbuffer_forwarding_en_in(rob_lbuffer_forwarding_en_in),
    .rob_lbuffer_forwarding_data_in(rob_lbuffer_forwarding_data_in),
    .lbuffer_datactrl_en_out(lbuffer_datactrl_en_out),
    .lbuffer_datactrl_addr_out(lbuffer_datactrl_addr_out),
    .lbuffer_datactrl_width_out(lbuffer_datactrl_width_out),
    .datactrl_lbuffer_en_in(datactrl_lbuffer_en_in),
    .datactrl_lbuffer_data_in(datactrl_lbuffer_data_in),
    .lbuffer_rob_h_out(lbuffer_rob_h_out),
    .lbuffer_rob_result_out(lbuffer_rob_result_out)
  );

  // Reference model: pending loads in program order plus "read outstanding".
  typedef struct {
    logic [ROB_W-1:0]       h;
    logic [INST_TYPE_W-1:0] op;
    logic [ADDR_W-1:0]      addr;
    bit                     av;
  } ld_t;

  ld_t              q[$];
  bit               m_mem;
  logic [ROB_W-1:0] exp_h;
  logic [ID_W-1:0]  exp_res;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Extension by arithmetic: take the low field, then fold into signed range.
  function automatic logic [31:0] ref_ext(input logic [3:0] op, input logic [31:0] d);
    longint dd, v;
    dd = longint'(d);
    case (op)
      OP_LB:   begin v = dd % 256;   if (v >= 128)   v = v - 256;   end
      OP_LH:   begin v = dd % 65536; if (v >= 32768) v = v - 65536; end
      OP_LBU:  v = dd % 256;
      OP_LHU:  v = dd % 65536;
      default: v = dd;
    endcase
    return v[31:0];
  endfunction

  // Width code is the access size in bytes.
  function automatic logic [31:0] ref_w(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU) return 1;
    if (op == OP_LH || op == OP_LHU) return 2;
    return 4;
  endfunction

  function automatic bit in_q(input logic [3:0] h);
    foreach (q[i]) if (q[i].h == h) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clr_in();
    dispatcher_lbuffer_en_in = 0; dispatcher_lbuffer_opcode_in = '0; dispatcher_lbuffer_h_in = '0;
    addrunit_lbuffer_h_in = '0; addrunit_lbuffer_address_in = '0;
    rob_lbuffer_disambiguation_in = 0; rob_lbuffer_forwarding_en_in = 0;
    rob_lbuffer_forwarding_data_in = '0; datactrl_lbuffer_en_in = 0;
    datactrl_lbuffer_data_in = '0; rob_rst_in = 0; rst_in = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    ld_t n;
    #1;
    chk("rob_index", lbuffer_rob_index_out, (q.size() > 0 && q[0].av) ? q[0].h : 4'd0);
    chk("dc_en", lbuffer_datactrl_en_out, m_mem && !datactrl_lbuffer_en_in);
    if (m_mem && !datactrl_lbuffer_en_in) begin
      chk("dc_addr", lbuffer_datactrl_addr_out, q[0].addr);
      chk("dc_width", lbuffer_datactrl_width_out, ref_w(q[0].op));
    end
    chk("rdy_out", lbuffer_rdy_out, q.size() <= DEPTH - 2);
    if (rst_in || (rdy_in && rob_rst_in)) begin
      q.delete(); m_mem = 0; exp_h = 0; exp_res = 0;
    end else if (rdy_in) begin
      exp_h = 0;
      if (m_mem && datactrl_lbuffer_en_in) begin
        exp_h = q[0].h; exp_res = ref_ext(q[0].op, datactrl_lbuffer_data_in);
        void'(q.pop_front()); m_mem = 0;
      end else if (!m_mem && q.size() > 0 && q[0].av) begin
`ifdef LBUFFER_FORWARD_EN
        if (rob_lbuffer_forwarding_en_in) begin
          exp_h = q[0].h; exp_res = ref_ext(q[0].op, rob_lbuffer_forwarding_data_in);
          void'(q.pop_front());
        end else
`endif
        if (rob_lbuffer_disambiguation_in) m_mem = 1;
      end
      if (dispatcher_lbuffer_en_in) begin
        n.h = dispatcher_lbuffer_h_in; n.op = dispatcher_lbuffer_opcode_in;
        n.addr = '0; n.av = 0; q.push_back(n);
      end
      if (addrunit_lbuffer_h_in != 0)
        foreach (q[i]) if (q[i].h == addrunit_lbuffer_h_in) begin
          q[i].av = 1; q[i].addr = addrunit_lbuffer_address_in;
        end
    end
    @(posedge clk_in); #1;
    chk("rob_h", lbuffer_rob_h_out, exp_h);
    chk("rob_result", lbuffer_rob_result_out, exp_res);
    clr_in();
  endtask

  // Single load: enqueue with address, optional stall, read, response.
  task automatic do_load(input logic [3:0] op, input logic [3:0] h, input logic [31:0] a,
                         input logic [31:0] data, input int stall, input logic [31:0] expv);
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = op; dispatcher_lbuffer_h_in = h;
    addrunit_lbuffer_h_in = h; addrunit_lbuffer_address_in = a;
    step();
    repeat (stall) step();
    rob_lbuffer_disambiguation_in = 1; step();
    step();
    datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = data; step();
    chk("ld_h", lbuffer_rob_h_out, h);
    chk("ld_res", lbuffer_rob_result_out, expv);
  endtask

  initial begin
    logic [3:0] cand[$];
    logic [3:0] nh;
    rdy_in = 1; clr_in();
    q.delete(); m_mem = 0; exp_h = 0; exp_res = 0;
    rst_in = 1;
    repeat (2) @(posedge clk_in);
    #1; rst_in = 0;
    chk("rst_h", lbuffer_rob_h_out, 0);
    chk("rst_res", lbuffer_rob_result_out, 0);
    chk("rst_en", lbuffer_datactrl_en_out, 0);
    chk("rst_rdy", lbuffer_rdy_out, 1);

    // LW, address one cycle after enqueue, three request cycles before data.
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LW; dispatcher_lbuffer_h_in = 3;
    step();
    addrunit_lbuffer_h_in = 3; addrunit_lbuffer_address_in = 32'h100; rob_lbuffer_disambiguation_in = 1;
    step();
    rob_lbuffer_disambiguation_in = 1; step();
    repeat (3) step();
    datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = 32'hDEADBEEF; step();
    chk("lw_h", lbuffer_rob_h_out, 3);
    chk("lw_res", lbuffer_rob_result_out, 32'hDEADBEEF);

    do_load(OP_LB,  5, 32'h104, 32'h00000080, 0, 32'hFFFFFF80);
    do_load(OP_LBU, 6, 32'h108, 32'h00000080, 0, 32'h00000080);
    do_load(OP_LH,  7, 32'h10C, 32'h00008001, 0, 32'hFFFF8001);
    do_load(OP_LHU, 8, 32'h110, 32'h00008001, 2, 32'h00008001);

    // Registered outputs hold while rdy_in is low.
    rdy_in = 0; step();
    chk("hold_h", lbuffer_rob_h_out, 8);
    rdy_in = 1; step();
    chk("pulse_h", lbuffer_rob_h_out, 0);

    // Head stalled on disambiguation; a ready younger load must wait.
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LW; dispatcher_lbuffer_h_in = 9;
    addrunit_lbuffer_h_in = 9; addrunit_lbuffer_address_in = 32'h200; step();
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LW; dispatcher_lbuffer_h_in = 10;
    addrunit_lbuffer_h_in = 10; addrunit_lbuffer_address_in = 32'h300; step();
    repeat (4) step();
    chk("stall_en", lbuffer_datactrl_en_out, 0);
    chk("stall_idx", lbuffer_rob_index_out, 9);
    rob_lbuffer_disambiguation_in = 1; step();
    chk("issue_en", lbuffer_datactrl_en_out, 1);
    chk("issue_addr", lbuffer_datactrl_addr_out, 32'h200);
    datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = 32'h1; step();
    chk("order_h0", lbuffer_rob_h_out, 9);
    rob_lbuffer_disambiguation_in = 1; step();
    datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = 32'h2; step();
    chk("order_h1", lbuffer_rob_h_out, 10);

    // Store-to-load forwarding of an LH.
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LH; dispatcher_lbuffer_h_in = 2;
    addrunit_lbuffer_h_in = 2; addrunit_lbuffer_address_in = 32'h400; step();
    rob_lbuffer_forwarding_en_in = 1; rob_lbuffer_forwarding_data_in = 32'h1234FFFE; step();
`ifdef LBUFFER_FORWARD_EN
    chk("fwd_h", lbuffer_rob_h_out, 2);
    chk("fwd_res", lbuffer_rob_result_out, 32'hFFFFFFFE);
    chk("fwd_no_read", lbuffer_datactrl_en_out, 0);
`else
    chk("nofwd_h", lbuffer_rob_h_out, 0);
    chk("nofwd_no_read", lbuffer_datactrl_en_out, 0);
    rob_lbuffer_disambiguation_in = 1; step();
    datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = 32'h1234FFFE; step();
    chk("nofwd_late_h", lbuffer_rob_h_out, 2);
    chk("nofwd_late_res", lbuffer_rob_result_out, 32'hFFFFFFFE);
`endif

    // Fill to seven entries; ready drops only once count passes six.
    for (int k = 0; k < 7; k++) begin
      dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LBU;
      dispatcher_lbuffer_h_in = 4'(k + 1); step();
      if (k == 5) chk("fill_rdy6", lbuffer_rdy_out, 1);
    end
    chk("fill_rdy7", lbuffer_rdy_out, 0);

    // Randomized traffic drains the fill and wraps the pointers repeatedly.
    for (int c = 0; c < 1500; c++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      rob_rst_in = ($urandom_range(0, 199) == 0);
      cand.delete();
      foreach (q[i]) if (!q[i].av) cand.push_back(q[i].h);
      if (q.size() <= DEPTH - 2 && $urandom_range(0, 2) == 0) begin
        do nh = 4'($urandom_range(1, 15)); while (in_q(nh));
        dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_h_in = nh;
        dispatcher_lbuffer_opcode_in = 4'($urandom_range(1, 5));
        cand.push_back(nh);
      end
      if (cand.size() > 0 && $urandom_range(0, 1) == 0) begin
        addrunit_lbuffer_h_in = cand[$urandom_range(0, cand.size() - 1)];
        addrunit_lbuffer_address_in = $urandom;
      end
      rob_lbuffer_disambiguation_in = $urandom_range(0, 1);
      rob_lbuffer_forwarding_en_in = ($urandom_range(0, 3) == 0);
      rob_lbuffer_forwarding_data_in = $urandom;
      if (m_mem && $urandom_range(0, 2) == 0) begin
        datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = $urandom;
      end
      step();
    end

    // Drain whatever is left, with a bounded cycle budget.
    rdy_in = 1;
    for (int c = 0; c < 300 && q.size() > 0; c++) begin
      foreach (q[i]) if (!q[i].av) begin
        addrunit_lbuffer_h_in = q[i].h; addrunit_lbuffer_address_in = $urandom; break;
      end
      rob_lbuffer_disambiguation_in = 1;
      if (m_mem) begin datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = $urandom; end
      step();
    end
    chk("drain_empty", q.size(), 0);

    // Flush while a read completes: response dropped, enqueue dropped.
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LW; dispatcher_lbuffer_h_in = 4;
    addrunit_lbuffer_h_in = 4; addrunit_lbuffer_address_in = 32'h500; step();
    rob_lbuffer_disambiguation_in = 1; step();
    step();
    rob_rst_in = 1; datactrl_lbuffer_en_in = 1; datactrl_lbuffer_data_in = 32'h55;
    dispatcher_lbuffer_en_in = 1; dispatcher_lbuffer_opcode_in = OP_LW; dispatcher_lbuffer_h_in = 6;
    addrunit_lbuffer_h_in = 6; addrunit_lbuffer_address_in = 32'h600;
    step();
    chk("flush_h", lbuffer_rob_h_out, 0);
    chk("flush_en", lbuffer_datactrl_en_out, 0);
    chk("flush_rdy", lbuffer_rdy_out, 1);
    chk("flush_idx", lbuffer_rob_index_out, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
